// File: rtl/divider_sixteen_bit_seq_if.sv
// Request/result bundle for the sequential unsigned divider.
// DIV_ZERO_FLAG_EN adds the div_zero result flag.
interface divider_sixteen_bit_seq_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
`ifdef DIV_ZERO_FLAG_EN
  logic             div_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_zero
  );
  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_zero
  );
`else
  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder
  );
  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder
  );
`endif
endinterface

// File: rtl/divider_sixteen_bit_seq.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock (IDLE -> RUN -> DONE).
// Optional feature macro: DIV_ZERO_FLAG_EN (adds the registered div_zero flag).
module divider_sixteen_bit_seq #(
  parameter int unsigned WIDTH = 16
) (
  input logic                      clk,
  input logic                      reset,
  divider_sixteen_bit_seq_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;

  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   trial;
  logic             accept;
  logic             last_iter;

  assign accept    = (state_q == StIdle) && bus.start;
  assign last_iter = (state_q == StRun) && (cnt_q == CntW'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.start) state_d = StRun;
      StRun:   if (cnt_q == CntW'(1)) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.busy = (state_q == StRun);
    bus.done = (state_q == StDone);
  end

  // R stays below D after every step, so WIDTH bits hold it; only the shifted value needs WIDTH+1.
  always_comb begin
    rem_shift   = {rem_q, quo_q[WIDTH-1]};
    trial       = rem_shift - {1'b0, div_q};
    rem_d       = rem_q;
    quo_d       = quo_q;
    div_d       = div_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    if (accept) begin
      rem_d = '0;
      quo_d = bus.dividend;
      div_d = bus.divisor;
      cnt_d = CntW'(WIDTH);
    end else if (state_q == StRun) begin
      if (!trial[WIDTH]) begin
        rem_d = trial[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = rem_shift[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end
      cnt_d = cnt_q - CntW'(1);
      // Publish on the final step so results are already valid while done is high.
      if (last_iter) begin
        quotient_d  = quo_d;
        remainder_d = rem_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q       <= '0;
      quo_q       <= '0;
      div_q       <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;

`ifdef DIV_ZERO_FLAG_EN
  logic div_zero_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      div_zero_q <= 1'b0;
    end else if (accept) begin
      div_zero_q <= (bus.divisor == '0);
    end
  end

  assign bus.div_zero = div_zero_q;
`endif

endmodule

// File: tb/tb_divider_sixteen_bit_seq.sv
// Self-checking bench: transaction-level model (plain / and %) compared every cycle,
// plus directed literal cases; randomized operand stream.
module tb_divider_sixteen_bit_seq;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   n_done = 0;
  bit   chk_en = 1'b0;

  divider_sixteen_bit_seq_if #(.WIDTH(W)) bus ();

  divider_sixteen_bit_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: ph=0 idle, 1..W running, W+1 done cycle.
  int           ph = 0;
  logic [W-1:0] pq, pr;
  logic [W-1:0] eq = '0, er = '0;
  logic         ez = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      ph <= 0;
      eq <= '0;
      er <= '0;
      ez <= 1'b0;
    end else if (ph == 0) begin
      if (bus.start) begin
        ph <= 1;
        pq <= (bus.divisor == 0) ? '1 : bus.dividend / bus.divisor;
        pr <= (bus.divisor == 0) ? bus.dividend : bus.dividend % bus.divisor;
        ez <= (bus.divisor == 0);
      end
    end else if (ph == W) begin
      ph <= W + 1;
      eq <= pq;
      er <= pr;
    end else if (ph == W + 1) begin
      ph <= 0;
    end else begin
      ph <= ph + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 32'(bus.busy), 32'(ph >= 1 && ph <= W));
      check("done", 32'(bus.done), 32'(ph == W + 1));
      check("quotient", 32'(bus.quotient), 32'(eq));
      check("remainder", 32'(bus.remainder), 32'(er));
`ifdef DIV_ZERO_FLAG_EN
      check("div_zero", 32'(bus.div_zero), 32'(ez));
`endif
      if (bus.done) n_done++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  logic dz_seen;

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r, output int lat);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    tick();
    bus.start = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.done && lat < 40);
    if (!bus.done) check("done_timeout", 32'(lat), 32'(W + 1));
    q = bus.quotient;
    r = bus.remainder;
`ifdef DIV_ZERO_FLAG_EN
    dz_seen = bus.div_zero;
`else
    dz_seen = 1'b0;
`endif
    tick();
  endtask

  logic [W-1:0] q, r, a, b;
  int           lat, d0;

  initial begin
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    do_op(16'd100, 16'd7, q, r, lat);
    check("t1_latency", 32'(lat), 32'd17);
    check("t1_q", 32'(q), 32'd14);
    check("t1_r", 32'(r), 32'd2);

    do_op(16'hFFFF, 16'h0001, q, r, lat);
    check("t2a_q", 32'(q), 32'hFFFF);
    check("t2a_r", 32'(r), 32'h0);
    do_op(16'hFFFF, 16'hFFFF, q, r, lat);
    check("t2b_q", 32'(q), 32'd1);
    check("t2b_r", 32'(r), 32'd0);

    do_op(16'd3, 16'd10, q, r, lat);
    check("t3a_q", 32'(q), 32'd0);
    check("t3a_r", 32'(r), 32'd3);
    do_op(16'd5, 16'd0, q, r, lat);
    check("t3b_q", 32'(q), 32'hFFFF);
    check("t3b_r", 32'(r), 32'd5);
`ifdef DIV_ZERO_FLAG_EN
    check("t3b_dz", 32'(dz_seen), 32'd1);
`endif
    tick();

    // Starts during RUN (cycle 3) and during DONE (cycle 17) must be dropped.
    bus.start    = 1'b1;
    bus.dividend = 16'd1000;
    bus.divisor  = 16'd9;
    tick();
    d0 = n_done;
    for (int c = 1; c <= 25; c++) begin
      bus.start    = (c == 3 || c == 17);
      bus.dividend = 16'd50;
      bus.divisor  = 16'd5;
      @(negedge clk);
      if (c == 17) check("t4_done_at_17", 32'(bus.done), 32'd1);
      tick();
    end
    check("t4_done_count", 32'(n_done - d0), 32'd1);
    check("t4_q", 32'(bus.quotient), 32'd111);
    check("t4_r", 32'(bus.remainder), 32'd1);

    // Reset mid-RUN aborts.
    bus.start    = 1'b1;
    bus.dividend = 16'd40000;
    bus.divisor  = 16'd123;
    tick();
    bus.start = 1'b0;
    repeat (7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t5_busy", 32'(bus.busy), 32'd0);
    check("t5_q", 32'(bus.quotient), 32'd0);
    check("t5_r", 32'(bus.remainder), 32'd0);
    d0 = n_done;
    repeat (20) tick();
    check("t5_no_done", 32'(n_done - d0), 32'd0);
    do_op(16'd40000, 16'd123, q, r, lat);
    check("t5_q2", 32'(q), 32'd325);
    check("t5_r2", 32'(r), 32'd25);

    // Back-to-back: second start lands the cycle after DONE.
    do_op(16'd77, 16'd4, q, r, lat);
    check("t6_q2", 32'(q), 32'd19);
    check("t6_r2", 32'(r), 32'd1);
    check("t6_latency", 32'(lat), 32'd17);

    // Reset and start together: request dropped.
    rst       = 1'b1;
    bus.start = 1'b1;
    tick();
    rst       = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    check("rst_start_busy", 32'(bus.busy), 32'd0);
    tick();

    for (int i = 0; i < 30; i++) begin
      a = W'($urandom);
      case ($urandom_range(0, 3))
        0:       b = '0;
        1:       b = W'($urandom_range(1, 15));
        2:       b = W'($urandom);
        default: b = (a == '1) ? a : a + W'($urandom_range(1, 100));
      endcase
      do_op(a, b, q, r, lat);
      check("rand_latency", 32'(lat), 32'd17);
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
